// File: rtl/alu_issue_ctrl.sv
// Issue controller that sequences one request at a time through an external fixed-latency ALU.
// Optional opcode checking is enabled by defining ALU_ISSUE_OPCHECK_EN.
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [3:0]  alu_c,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_s,
    input  logic        alu_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_s,
    output logic        out_cout,
    output logic        out_zero,
    output logic        out_err,
    output logic        busy,
    output logic [15:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  alu_c_q, alu_c_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [7:0]  out_s_q, out_s_d;
    logic        out_cout_q, out_cout_d;
    logic        out_zero_q, out_zero_d;
    logic        out_err_q, out_err_d;
    logic [15:0] ops_done_q, ops_done_d;

    logic op_bad;
    logic accept;
    logic capture;
    logic retire;

`ifdef ALU_ISSUE_OPCHECK_EN
    assign op_bad = (in_op == 4'b0000) || (in_op == 4'b0101) ||
                    (in_op == 4'b1110) || (in_op == 4'b1111);
`else
    assign op_bad = 1'b0;
`endif

    assign accept  = (state_q == IDLE) && in_valid;
    assign capture = (state_q == EXEC) && (cnt_q == 4'd0);
    assign retire  = (state_q == DONE) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = op_bad ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        cnt_d      = cnt_q;
        alu_c_d    = alu_c_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        out_s_d    = out_s_q;
        out_cout_d = out_cout_q;
        out_zero_d = out_zero_q;
        out_err_d  = out_err_q;
        ops_done_d = ops_done_q;

        if (accept && !op_bad) begin
            alu_c_d = in_op;
            alu_a_d = in_a;
            alu_b_d = in_b;
            cnt_d   = LAT_M1;
        end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        // Rejected opcodes never reach the ALU; they complete with a canned error result.
        if (accept && op_bad) begin
            out_s_d    = 8'h00;
            out_cout_d = 1'b0;
            out_zero_d = 1'b1;
            out_err_d  = 1'b1;
        end

        if (capture) begin
            out_s_d    = alu_s;
            out_cout_d = alu_cout;
            out_zero_d = (alu_s == 8'h00);
            out_err_d  = 1'b0;
        end

        if (retire) begin
            ops_done_d = ops_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            alu_c_q    <= 4'd0;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            out_s_q    <= 8'h00;
            out_cout_q <= 1'b0;
            out_zero_q <= 1'b1;
            out_err_q  <= 1'b0;
            ops_done_q <= 16'd0;
        end else begin
            cnt_q      <= cnt_d;
            alu_c_q    <= alu_c_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            out_s_q    <= out_s_d;
            out_cout_q <= out_cout_d;
            out_zero_q <= out_zero_d;
            out_err_q  <= out_err_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign alu_c    = alu_c_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign out_s    = out_s_q;
    assign out_cout = out_cout_q;
    assign out_zero = out_zero_q;
    assign out_err  = out_err_q;
    assign ops_done = ops_done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three instances (ALU_LAT 1, 3, 4), each with a stub ALU,
// directed corner cases followed by randomized transactions against a reference model.
module tb_alu_issue_ctrl;

  localparam int NDUT = 3;

`ifdef ALU_ISSUE_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [3:0]  in_op     [NDUT];
  logic [7:0]  in_a      [NDUT];
  logic [7:0]  in_b      [NDUT];
  logic [3:0]  alu_c     [NDUT];
  logic [7:0]  alu_a     [NDUT];
  logic [7:0]  alu_b     [NDUT];
  logic [7:0]  alu_s     [NDUT];
  logic        alu_cout  [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [7:0]  out_s     [NDUT];
  logic        out_cout  [NDUT];
  logic        out_zero  [NDUT];
  logic        out_err   [NDUT];
  logic        busy      [NDUT];
  logic [15:0] ops_done  [NDUT];

  // Reference model state
  logic [15:0] exp_cnt [NDUT];
  logic [3:0]  last_c  [NDUT];
  logic [7:0]  last_a  [NDUT];
  logic [7:0]  last_b  [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [8:0] sum;
    assign sum         = {1'b0, alu_a[g]} + {1'b0, alu_b[g]};
    assign alu_s[g]    = (alu_c[g] == 4'b0001) ? sum[7:0] : (alu_a[g] ^ alu_b[g]);
    assign alu_cout[g] = (alu_c[g] == 4'b0001) ? sum[8] : 1'b0;

    alu_issue_ctrl #(
      .ALU_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_op    (in_op[g]),
      .in_a     (in_a[g]),
      .in_b     (in_b[g]),
      .alu_c    (alu_c[g]),
      .alu_a    (alu_a[g]),
      .alu_b    (alu_b[g]),
      .alu_s    (alu_s[g]),
      .alu_cout (alu_cout[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_s    (out_s[g]),
      .out_cout (out_cout[g]),
      .out_zero (out_zero[g]),
      .out_err  (out_err[g]),
      .busy     (busy[g]),
      .ops_done (ops_done[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return OPCHK && ((op == 4'h0) || (op == 4'h5) || (op == 4'hE) || (op == 4'hF));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      exp_cnt[i] = 16'd0;
      last_c[i]  = 4'd0;
      last_a[i]  = 8'h00;
      last_b[i]  = 8'h00;
    end
  endtask

  task automatic check_reset_vals(input int i);
    chk("rst_in_ready",  in_ready[i],  1'b1);
    chk("rst_busy",      busy[i],      1'b0);
    chk("rst_out_valid", out_valid[i], 1'b0);
    chk("rst_alu_c",     alu_c[i],     4'h0);
    chk("rst_alu_a",     alu_a[i],     8'h00);
    chk("rst_alu_b",     alu_b[i],     8'h00);
    chk("rst_out_s",     out_s[i],     8'h00);
    chk("rst_out_cout",  out_cout[i],  1'b0);
    chk("rst_out_zero",  out_zero[i],  1'b1);
    chk("rst_out_err",   out_err[i],   1'b0);
    chk("rst_ops_done",  ops_done[i],  16'd0);
  endtask

  // One full request on instance i, called at a negedge with the instance idle.
  task automatic txn(input int i, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input int stall);
    logic       ill;
    int         lat;
    logic [8:0] sum;
    logic [7:0] es;
    logic       ec, ez, ee;
    ill = is_illegal(op);
    if (ill) begin
      es = 8'h00; ec = 1'b0; ee = 1'b1; lat = 0;
    end else begin
      sum = {1'b0, a} + {1'b0, b};
      if (op == 4'b0001) begin
        es = sum[7:0]; ec = sum[8];
      end else begin
        es = a ^ b; ec = 1'b0;
      end
      ee = 1'b0;
      lat = lat_of(i);
      last_c[i] = op; last_a[i] = a; last_b[i] = b;
    end
    ez = (es == 8'h00);

    chk("idle_in_ready", in_ready[i], 1'b1);
    in_valid[i]  = 1'b1;
    in_op[i]     = op;
    in_a[i]      = a;
    in_b[i]      = b;
    out_ready[i] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_op[i] = 4'($urandom);
    in_a[i]  = 8'($urandom);
    in_b[i]  = 8'($urandom);
    for (int k = 0; k < lat; k++) begin
      chk("exec_out_valid", out_valid[i], 1'b0);
      chk("exec_busy",      busy[i],      1'b1);
      chk("exec_in_ready",  in_ready[i],  1'b0);
      chk("exec_alu_a",     alu_a[i],     last_a[i]);
      @(negedge clk);
    end
    chk("done_out_valid", out_valid[i], 1'b1);
    chk("done_out_s",     out_s[i],     es);
    chk("done_out_cout",  out_cout[i],  ec);
    chk("done_out_zero",  out_zero[i],  ez);
    chk("done_out_err",   out_err[i],   ee);
    chk("done_alu_c",     alu_c[i],     last_c[i]);
    chk("done_alu_a",     alu_a[i],     last_a[i]);
    chk("done_alu_b",     alu_b[i],     last_b[i]);
    chk("done_ops_done",  ops_done[i],  exp_cnt[i]);
    for (int s = 0; s < stall; s++) begin
      in_a[i] = 8'($urandom);
      @(negedge clk);
      chk("stall_out_valid", out_valid[i], 1'b1);
      chk("stall_out_s",     out_s[i],     es);
      chk("stall_out_zero",  out_zero[i],  ez);
      chk("stall_out_cout",  out_cout[i],  ec);
      chk("stall_out_err",   out_err[i],   ee);
      chk("stall_in_ready",  in_ready[i],  1'b0);
      chk("stall_ops_done",  ops_done[i],  exp_cnt[i]);
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    exp_cnt[i] = exp_cnt[i] + 16'd1;
    chk("rel_ops_done",  ops_done[i],  exp_cnt[i]);
    chk("rel_busy",      busy[i],      1'b0);
    chk("rel_in_ready",  in_ready[i],  1'b1);
    chk("rel_out_valid", out_valid[i], 1'b0);
    chk("rel_alu_a",     alu_a[i],     last_a[i]);
    in_valid[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i]  = 1'b0;
      in_op[i]     = 4'd0;
      in_a[i]      = 8'h00;
      in_b[i]      = 8'h00;
      out_ready[i] = 1'b1;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) check_reset_vals(i);
    rst = 1'b0;
    @(negedge clk);

    txn(0, 4'b0001, 8'h32, 8'h32, 0);
    n_checks++;
    if (ops_done[0] !== 16'd1) begin
      n_fail++;
      $error("FAIL first_ops_done observed=%0h", ops_done[0]);
    end
    txn(1, 4'b0001, 8'hCE, 8'hB5, 0);
    txn(0, 4'b0010, 8'h64, 8'h64, 5);
    txn(0, 4'b0101, 8'hCD, 8'h0F, 0);
    txn(1, 4'b0101, 8'hCD, 8'h3C, 2);
    txn(2, 4'b0001, 8'hFF, 8'h01, 1);
    txn(2, 4'b1111, 8'h12, 8'h34, 0);

    in_valid[2] = 1'b1;
    in_op[2]    = 4'b0001;
    in_a[2]     = 8'h11;
    in_b[2]     = 8'h22;
    @(posedge clk);
    @(negedge clk);
    in_valid[2] = 1'b0;
    n_checks++;
    if (busy[2] !== 1'b1) begin
      n_fail++;
      $error("FAIL mid_busy observed=%0h", busy[2]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_vals(2);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready[2] !== 1'b1) begin
      n_fail++;
      $error("FAIL post_rst_in_ready observed=%0h", in_ready[2]);
    end
    n_checks++;
    if (out_valid[2] !== 1'b0) begin
      n_fail++;
      $error("FAIL post_rst_out_valid observed=%0h", out_valid[2]);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid[2] !== 1'b0) begin
        n_fail++;
        $error("FAIL post_rst_no_valid observed=%0h", out_valid[2]);
      end
      n_checks++;
      if (ops_done[2] !== 16'd0) begin
        n_fail++;
        $error("FAIL post_rst_ops_done observed=%0h", ops_done[2]);
      end
    end

    force g_dut[0].u_dut.ops_done_q = 16'hFFFE;
    #1;
    release g_dut[0].u_dut.ops_done_q;
    exp_cnt[0] = 16'hFFFE;
    @(negedge clk);
    txn(0, 4'b0011, 8'hA5, 8'h5A, 0);
    txn(0, 4'b0001, 8'h80, 8'h80, 1);
    n_checks++;
    if (ops_done[0] !== 16'h0000) begin
      n_fail++;
      $error("FAIL wrap_ops_done observed=%0h", ops_done[0]);
    end

    for (int n = 0; n < 60; n++) begin
      int i;
      i = int'($urandom_range(0, NDUT - 1));
      txn(i, 4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
